// File: rtl/dm_wait.sv
// dm_wait: 32-bit single-port data memory with byte/half/word access,
// sign/zero extension on loads and a fixed number of wait states per access.
// Every access runs IDLE -> WAIT (x WAIT cycles) -> DONE; misaligned or
// illegal-op accesses complete with err=1 and never touch the array.
module dm_wait #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       din,
  input  logic [2:0]        dmop,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [31:0]       dout
);

  localparam logic [2:0] OP_WORD   = 3'b000;
  localparam logic [2:0] OP_HALF_U = 3'b001;
  localparam logic [2:0] OP_HALF_S = 3'b010;
  localparam logic [2:0] OP_BYTE_U = 3'b011;
  localparam logic [2:0] OP_BYTE_S = 3'b100;

  // Last value of the wait counter before leaving WAIT; unused when WAIT=0.
  localparam logic [3:0] WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // Misaligned word/half or an undefined op code.
  function automatic logic access_bad(input logic [2:0] op, input logic [1:0] lane);
    logic bad;
    case (op)
      OP_WORD:              bad = (lane != 2'b00);
      OP_HALF_U, OP_HALF_S: bad = lane[0];
      OP_BYTE_U, OP_BYTE_S: bad = 1'b0;
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Merge right-aligned store data into the addressed lanes of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (op)
      OP_WORD: w = data;
      OP_HALF_U, OP_HALF_S: begin
        if (lane[1]) w[31:16] = data[15:0];
        else         w[15:0]  = data[15:0];
      end
      default: w[{lane, 3'b000} +: 8] = data[7:0];
    endcase
    return w;
  endfunction

  // Shift the selected lane down to bit 0 and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  op,
                                               input logic [1:0]  lane);
    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;
    logic [31:0]        r;
    half_s = lane[1] ? word[31:16] : word[15:0];
    byte_s = word[{lane, 3'b000} +: 8];
    case (op)
      OP_WORD:   r = word;
      OP_HALF_U: r = {16'h0000, half_s};
      OP_HALF_S: r = {{16{half_s[15]}}, half_s};
      OP_BYTE_U: r = {24'h000000, byte_s};
      OP_BYTE_S: r = {{24{byte_s[7]}}, byte_s};
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;

  // Request captured at acceptance; live inputs are ignored until IDLE.
  logic [ADDR_W+1:0] addr_p0;
  logic              we_p0;
  logic [31:0]       din_p0;
  logic [2:0]        op_p0;

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W+1:0] cur_addr;
  logic              cur_we;
  logic [31:0]       cur_din;
  logic [2:0]        cur_op;
  logic [ADDR_W-1:0] cur_word;
  logic [1:0]        cur_lane;
  logic              cur_bad;
  logic [31:0]       rd_word;
  logic              accept;
  logic              enter_done;
  logic              mem_wr;

  assign accept = (state == S_IDLE) && req;
  assign busy   = (state != S_IDLE);

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req) next_state = (WAIT == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == WAIT_LAST) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // With WAIT=0 the commit edge is the accepting edge, so the live inputs
  // must be used directly; otherwise the captured request is used.
  always_comb begin
    cur_addr = addr_p0;
    cur_we   = we_p0;
    cur_din  = din_p0;
    cur_op   = op_p0;
    if (state == S_IDLE) begin
      cur_addr = addr;
      cur_we   = we;
      cur_din  = din;
      cur_op   = dmop;
    end
  end

  assign cur_word   = cur_addr[ADDR_W+1:2];
  assign cur_lane   = cur_addr[1:0];
  assign cur_bad    = access_bad(cur_op, cur_lane);
  assign rd_word    = mem[cur_word];
  assign enter_done = (next_state == S_DONE);
  assign mem_wr     = enter_done && cur_we && !cur_bad;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Wait counter: cleared on acceptance, advanced in WAIT.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= 4'd0;
    else if (accept)           cnt <= 4'd0;
    else if (state == S_WAIT)  cnt <= cnt + 4'd1;
  end

  // Request capture stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p0 <= '0;
      we_p0   <= 1'b0;
      din_p0  <= 32'h0000_0000;
      op_p0   <= 3'b000;
    end else if (accept) begin
      addr_p0 <= addr;
      we_p0   <= we;
      din_p0  <= din;
      op_p0   <= dmop;
    end
  end

  // Memory array: commit on the edge entering DONE; reset never blocks
  // contents but does suppress a commit on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) mem[cur_word] <= store_merge(rd_word, cur_din, cur_op, cur_lane);
  end

  // Completion stage: ack/err pulse for DONE, dout updated only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack  <= 1'b0;
      err  <= 1'b0;
      dout <= 32'h0000_0000;
    end else begin
      ack <= enter_done;
      err <= enter_done && cur_bad;
      if (enter_done) begin
        if (cur_bad || cur_we) dout <= 32'h0000_0000;
        else                   dout <= load_extract(rd_word, cur_op, cur_lane);
      end
    end
  end

endmodule

// File: tb/tb_dm_wait.sv
// tb_dm_wait: directed bench for dm_wait with one instance at WAIT=2 and
// one at WAIT=0; expected values are hand-computed constants.
module tb_dm_wait;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_a, we_a, busy_a, ack_a, err_a;
  logic [11:0] addr_a;
  logic [31:0] din_a, dout_a;
  logic [2:0]  dmop_a;

  logic        req_b, we_b, busy_b, ack_b, err_b;
  logic [11:0] addr_b;
  logic [31:0] din_b, dout_b;
  logic [2:0]  dmop_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_cnt_a = 0;

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          c0;
  int          t0, t1, nack;

  dm_wait #(.ADDR_W(10), .WAIT(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .din(din_a),
    .dmop(dmop_a), .busy(busy_a), .ack(ack_a), .err(err_a), .dout(dout_a)
  );

  dm_wait #(.ADDR_W(10), .WAIT(0)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .din(din_b),
    .dmop(dmop_b), .busy(busy_b), .ack(ack_b), .err(err_b), .dout(dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (ack_a) ack_cnt_a <= ack_cnt_a + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on instance a (sel=0) or b (sel=1); returns data, err and the
  // number of edges from the accepting edge to the edge that samples ack.
  task automatic access(input bit sel, input logic w, input logic [11:0] a,
                        input logic [31:0] d, input logic [2:0] op,
                        output logic [31:0] rdata, output logic rerr, output int rlat);
    @(negedge clk);
    if (sel) begin
      req_b = 1'b1; we_b = w; addr_b = a; din_b = d; dmop_b = op;
    end else begin
      req_a = 1'b1; we_a = w; addr_a = a; din_a = d; dmop_a = op;
    end
    @(posedge clk);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
    rdata = 32'h0;
    rerr  = 1'b0;
    rlat  = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        rdata = sel ? dout_b : dout_a;
        rerr  = sel ? err_b : err_a;
        rlat  = n + 1;
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_a = 0; we_a = 0; addr_a = 0; din_a = 0; dmop_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; din_b = 0; dmop_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_ack", 32'(ack_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    check_eq("rst_dout", dout_a, 32'h0);
    check_eq("rst_busy_b", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // word store then load
    access(0, 1'b1, 12'h010, 32'hDEADBEEF, 3'b000, rd, e, lat);
    check_eq("st_word_err", 32'(e), 32'd0);
    check_eq("st_word_dout", rd, 32'h0);
    check_eq("st_word_lat", 32'(lat), 32'd3);
    access(0, 1'b0, 12'h010, 32'h0, 3'b000, rd, e, lat);
    check_eq("ld_word", rd, 32'hDEADBEEF);
    check_eq("ld_word_err", 32'(e), 32'd0);
    check_eq("ld_word_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check_eq("ack_one_cycle", 32'(ack_a), 32'd0);
    check_eq("dout_hold", dout_a, 32'hDEADBEEF);

    // lane store and extension
    access(0, 1'b1, 12'h013, 32'h0000005A, 3'b011, rd, e, lat);
    check_eq("st_byte_err", 32'(e), 32'd0);
    access(0, 1'b0, 12'h010, 32'h0, 3'b000, rd, e, lat);
    check_eq("ld_after_byte", rd, 32'h5AADBEEF);
    access(0, 1'b0, 12'h012, 32'h0, 3'b100, rd, e, lat);
    check_eq("ld_byte_s", rd, 32'hFFFFFFAD);
    access(0, 1'b0, 12'h012, 32'h0, 3'b001, rd, e, lat);
    check_eq("ld_half_u", rd, 32'h00005AAD);

    // error paths
    access(0, 1'b0, 12'h011, 32'h0, 3'b000, rd, e, lat);
    check_eq("misal_err", 32'(e), 32'd1);
    check_eq("misal_dout", rd, 32'h0);
    check_eq("misal_lat", 32'(lat), 32'd3);
    access(0, 1'b1, 12'h010, 32'h11111111, 3'b111, rd, e, lat);
    check_eq("illegal_err", 32'(e), 32'd1);
    access(0, 1'b1, 12'h011, 32'h00002222, 3'b001, rd, e, lat);
    check_eq("misal_half_st_err", 32'(e), 32'd1);
    access(0, 1'b0, 12'h010, 32'h0, 3'b000, rd, e, lat);
    check_eq("mem_unchanged", rd, 32'h5AADBEEF);
    check_eq("mem_unchanged_err", 32'(e), 32'd0);

    // request while busy is dropped
    @(posedge clk);
    c0 = ack_cnt_a;
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; addr_a = 12'h010; dmop_a = 3'b000;
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    check_eq("busy_in_wait", 32'(busy_a), 32'd1);
    req_a = 1'b1; addr_a = 12'h014;
    @(negedge clk);
    req_a = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    check_eq("busy_reject_acks", 32'(ack_cnt_a - c0), 32'd1);

    // held request gives back-to-back accesses
    c0 = ack_cnt_a;
    nack = 0; t0 = 0; t1 = 0;
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; addr_a = 12'h010; dmop_a = 3'b000;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack_a === 1'b1) begin
        if (nack == 0) t0 = cyc;
        else           t1 = cyc;
        nack++;
        if (nack == 2) begin
          req_a = 1'b0;
          break;
        end
      end
    end
    req_a = 1'b0;
    check_eq("b2b_count", 32'(nack), 32'd2);
    check_eq("b2b_spacing", 32'(t1 - t0), 32'd4);
    repeat (8) @(negedge clk);
    @(posedge clk);
    check_eq("b2b_total_acks", 32'(ack_cnt_a - c0), 32'd2);

    // reset at the commit edge aborts a store
    access(0, 1'b1, 12'h020, 32'h00000000, 3'b000, rd, e, lat);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 12'h020; din_a = 32'h12345678; dmop_a = 3'b000;
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    c0 = ack_cnt_a;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    check_eq("abort_ack", 32'(ack_a), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    check_eq("abort_no_ack", 32'(ack_cnt_a - c0), 32'd0);
    access(0, 1'b0, 12'h020, 32'h0, 3'b000, rd, e, lat);
    check_eq("abort_no_write", rd, 32'h00000000);
    access(0, 1'b0, 12'h010, 32'h0, 3'b000, rd, e, lat);
    check_eq("mem_kept_over_rst", rd, 32'h5AADBEEF);

    // zero wait states
    access(1, 1'b1, 12'h040, 32'h00008001, 3'b000, rd, e, lat);
    check_eq("w0_st_lat", 32'(lat), 32'd1);
    check_eq("w0_st_err", 32'(e), 32'd0);
    access(1, 1'b0, 12'h040, 32'h0, 3'b010, rd, e, lat);
    check_eq("w0_ld_half_s", rd, 32'hFFFF8001);
    check_eq("w0_ld_lat", 32'(lat), 32'd1);
    access(1, 1'b0, 12'h041, 32'h0, 3'b100, rd, e, lat);
    check_eq("w0_ld_byte_s", rd, 32'hFFFFFF80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
